// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I fetch unit: PC, Imem request, response FIFO, redirect
module instr_fetch_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int               DEPTH    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] iaddr,
   input  logic [WIDTH-1:0] idata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_instr,
   output logic [WIDTH-1:0] out_pc,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] req_pc;
   logic             req_valid;

   logic [WIDTH-1:0] fifo_instr [DEPTH];
   logic [WIDTH-1:0] fifo_pc    [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count;

   logic             pop;
   logic             push;
   logic             issue;
   logic [CW:0]      occ;

   // Handshake and credit: only issue a read when its response is guaranteed a FIFO slot
   always_comb begin
      pop   = 1'b0;
      push  = 1'b0;
      issue = 1'b0;
      occ   = '0;
      pop   = (count != '0) && out_ready && !redirect_valid;
      push  = req_valid && !redirect_valid;
      occ   = {1'b0, count} + (CW+1)'(req_valid) - (CW+1)'(pop);
      issue = !redirect_valid && (occ < (CW+1)'(DEPTH));
   end

   // Outputs come straight from PC and the FIFO head storage
   always_comb begin
      iaddr     = {2'b00, pc[WIDTH-1:2]};
      out_valid = (count != '0);
      out_instr = fifo_instr[rd_ptr];
      out_pc    = fifo_pc[rd_ptr];
   end

   // PC and in-flight request tracking; redirect wins over everything else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         req_valid <= 1'b0;
         req_pc    <= '0;
      end else if (redirect_valid) begin
         pc        <= redirect_pc & ~(WIDTH'(3));
         req_valid <= 1'b0;
      end else if (issue) begin
         req_valid <= 1'b1;
         req_pc    <= pc;
         pc        <= pc + WIDTH'(4);
      end else begin
         req_valid <= 1'b0;
      end
   end

   // Response FIFO: push captured {req_pc, idata}, pop on accept, flush on redirect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
         end
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_instr[wr_ptr] <= idata;
            fifo_pc[wr_ptr]    <= req_pc;
            wr_ptr             <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule
